// File: rtl/inst_dispatch_pkg.sv
// Shared widths, opcodes, instruction payload, lane states and opcode decode
// helpers for the two-lane instruction dispatcher.
package inst_dispatch_pkg;

    localparam int unsigned INS_PART_WID  = 4;
    localparam int unsigned NUM_REGS      = 2 ** INS_PART_WID;
    localparam int unsigned FETCH_TIMEOUT = 8;
    localparam int unsigned CNT_WID       = 8;
    localparam int unsigned TMO_WID       = $clog2(FETCH_TIMEOUT);

    typedef logic [INS_PART_WID-1:0] field_t;

    localparam field_t OP_NOP = field_t'(0);
    localparam field_t OP_ADD = field_t'(1);
    localparam field_t OP_SUB = field_t'(2);
    localparam field_t OP_MUL = field_t'(3);
    localparam field_t OP_LD  = field_t'(4);
    localparam field_t OP_ST  = field_t'(5);

    typedef struct packed {
        field_t op;
        field_t dest;
        field_t src0;
        field_t src1;
    } inst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } lane_state_t;

    function automatic logic is_legal(field_t op);
        return op <= OP_ST;
    endfunction

    function automatic logic uses_dest(field_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_LD);
    endfunction

    function automatic logic uses_src0(field_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic uses_src1(field_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_ST);
    endfunction

    // RAW on any used source or WAW on the destination against the busy vector.
    function automatic logic reg_hazard(inst_t i, logic [NUM_REGS-1:0] busy);
        return (uses_src0(i.op) & busy[i.src0]) |
               (uses_src1(i.op) & busy[i.src1]) |
               (uses_dest(i.op) & busy[i.dest]);
    endfunction

    // True when instruction i reads or writes register r.
    function automatic logic reg_conflict(inst_t i, field_t r);
        return (uses_src0(i.op) && (i.src0 == r)) ||
               (uses_src1(i.op) && (i.src1 == r)) ||
               (uses_dest(i.op) && (i.dest == r));
    endfunction

endpackage

// File: rtl/inst_dispatch_lane.sv
// One dispatch lane: fetch FSM with timeout, capture register and the
// dispatch valid/ready handshake gated by the hazard computed upstream.
module dispatch_lane
    import inst_dispatch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inst_valid,
    input  inst_t inst_in,
    input  logic  disp_ready,
    input  logic  hazard,
    output logic  fetch,
    output inst_t held,
    output logic  disp_valid_c,
    output logic  xfer_c,
    output logic  illegal_c
);

    lane_state_t        state_q, state_d;
    logic [TMO_WID-1:0] tmo_q, tmo_d;
    logic               cap_en;

    assign disp_valid_c = (state_q == ST_HOLD) & ~hazard;
    assign xfer_c       = disp_valid_c & disp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            fetch   <= 1'b0;
            held    <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            fetch   <= (state_d == ST_REQ);
            if (cap_en) held <= inst_in;
        end
    end

    // Next state; illegal opcodes are dropped without leaving REQ.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        cap_en    = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                tmo_d   = '0;
            end
            ST_REQ: begin
                if (inst_valid) begin
                    tmo_d = '0;
                    if (is_legal(inst_in.op)) begin
                        cap_en  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        illegal_c = 1'b1;
                    end
                end else if (tmo_q == TMO_WID'(FETCH_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_WID'(1);
                end
            end
            ST_HOLD: begin
                if (xfer_c) begin
                    state_d = ST_REQ;
                    tmo_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/inst_dispatch.sv
// Two-lane instruction dispatcher: register scoreboard with writeback bypass,
// lane1-before-lane2 ordering hazard and a saturating illegal-opcode counter.
module inst_dispatch
    import inst_dispatch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    inst_1_fetch,
    input  logic                    inst_1_valid,
    input  logic [INS_PART_WID-1:0] inst_1_type,
    input  logic [INS_PART_WID-1:0] inst_1_dest,
    input  logic [INS_PART_WID-1:0] inst_1_src0,
    input  logic [INS_PART_WID-1:0] inst_1_src1,
    output logic                    inst_2_fetch,
    input  logic                    inst_2_valid,
    input  logic [INS_PART_WID-1:0] inst_2_type,
    input  logic [INS_PART_WID-1:0] inst_2_dest,
    input  logic [INS_PART_WID-1:0] inst_2_src0,
    input  logic [INS_PART_WID-1:0] inst_2_src1,
    output logic                    disp_1_valid,
    input  logic                    disp_1_ready,
    output logic [INS_PART_WID-1:0] disp_1_op,
    output logic [INS_PART_WID-1:0] disp_1_dest,
    output logic [INS_PART_WID-1:0] disp_1_src0,
    output logic [INS_PART_WID-1:0] disp_1_src1,
    output logic                    disp_2_valid,
    input  logic                    disp_2_ready,
    output logic [INS_PART_WID-1:0] disp_2_op,
    output logic [INS_PART_WID-1:0] disp_2_dest,
    output logic [INS_PART_WID-1:0] disp_2_src0,
    output logic [INS_PART_WID-1:0] disp_2_src1,
    input  logic                    wb_valid,
    input  logic [INS_PART_WID-1:0] wb_reg,
    output logic                    illegal_pulse,
    output logic [CNT_WID-1:0]      illegal_cnt
);

    localparam int unsigned CNT_SUM_WID = CNT_WID + 1;

    inst_t                 in1, in2, held1, held2;
    logic                  haz1, haz2, xfer1, xfer2, ill1, ill2;
    logic [NUM_REGS-1:0]   busy_q, busy_d, busy_eff, wb_clr, disp_set;
    logic [CNT_SUM_WID-1:0] cnt_sum;

    assign in1 = '{op: inst_1_type, dest: inst_1_dest, src0: inst_1_src0, src1: inst_1_src1};
    assign in2 = '{op: inst_2_type, dest: inst_2_dest, src0: inst_2_src0, src1: inst_2_src1};

    dispatch_lane u_lane1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid   (inst_1_valid),
        .inst_in      (in1),
        .disp_ready   (disp_1_ready),
        .hazard       (haz1),
        .fetch        (inst_1_fetch),
        .held         (held1),
        .disp_valid_c (disp_1_valid),
        .xfer_c       (xfer1),
        .illegal_c    (ill1)
    );

    dispatch_lane u_lane2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid   (inst_2_valid),
        .inst_in      (in2),
        .disp_ready   (disp_2_ready),
        .hazard       (haz2),
        .fetch        (inst_2_fetch),
        .held         (held2),
        .disp_valid_c (disp_2_valid),
        .xfer_c       (xfer2),
        .illegal_c    (ill2)
    );

    assign {disp_1_op, disp_1_dest, disp_1_src0, disp_1_src1} = held1;
    assign {disp_2_op, disp_2_dest, disp_2_src0, disp_2_src1} = held2;

    // Writeback clears before the hazard check so a reader can issue in the wb cycle.
    always_comb begin
        wb_clr = '0;
        if (wb_valid) wb_clr[wb_reg] = 1'b1;
    end

    assign busy_eff = busy_q & ~wb_clr;

    // Lane 2 is younger: it also waits on lane 1's same-cycle destination.
    assign haz1 = reg_hazard(held1, busy_eff);
    assign haz2 = reg_hazard(held2, busy_eff) |
                  (xfer1 & uses_dest(held1.op) & reg_conflict(held2, held1.dest));

    always_comb begin
        disp_set = '0;
        if (xfer1 && uses_dest(held1.op)) disp_set[held1.dest] = 1'b1;
        if (xfer2 && uses_dest(held2.op)) disp_set[held2.dest] = 1'b1;
        busy_d = busy_eff | disp_set;
    end

    assign cnt_sum = {1'b0, illegal_cnt} + CNT_SUM_WID'(ill1) + CNT_SUM_WID'(ill2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            illegal_pulse <= 1'b0;
            illegal_cnt   <= '0;
        end else begin
            busy_q        <= busy_d;
            illegal_pulse <= ill1 | ill2;
            illegal_cnt   <= cnt_sum[CNT_WID] ? '1 : cnt_sum[CNT_WID-1:0];
        end
    end

endmodule
